// File: rtl/esi_mmio_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ MMIO requesters onto one AXI-lite master port.
// One transaction is outstanding at a time; the completion is strobed back to its owner.
module esi_mmio_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [32*NUM_REQ-1:0]   req_addr,
  input  logic [32*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [31:0]             resp_data,
  output logic [1:0]              resp_err,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [31:0]             araddr,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [31:0]             rdata,
  input  logic [1:0]              rresp,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [31:0]             awaddr,
  output logic                    wvalid,
  input  logic                    wready,
  output logic [31:0]             wdata,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [1:0]              bresp
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_RESP, WR_ADDR, WR_RESP, RESP} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   id_q, id_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     data_q, data_d;
  logic [1:0]      err_q, err_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;

  logic            gnt_found;
  logic [IW-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt_oh;
  logic            gnt_write;
  logic [31:0]     gnt_addr;
  logic [31:0]     gnt_wdata;
  int unsigned     scan_idx;

  // Scan from the pointer upward, wrapping, and take the first requester found.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = 32'(ptr_q) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!gnt_found && req_valid[IW'(scan_idx)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(scan_idx);
      end
    end
    gnt_oh    = '0;
    gnt_write = 1'b0;
    gnt_addr  = '0;
    gnt_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (i == 32'(gnt_idx)) begin
        gnt_oh[i] = gnt_found;
        gnt_write = req_write[i];
        gnt_addr  = req_addr[32*i +: 32];
        gnt_wdata = req_wdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    data_d    = data_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          id_d      = gnt_idx;
          ptr_d     = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
          addr_d    = gnt_addr;
          wdata_d   = gnt_wdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = gnt_write ? WR_ADDR : RD_ADDR;
        end
      end
      RD_ADDR: if (arready) state_d = RD_RESP;
      RD_RESP: begin
        if (rvalid) begin
          data_d  = rdata;
          err_d   = rresp;
          state_d = RESP;
        end
      end
      WR_ADDR: begin
        // Address and data channels complete independently; advance once both are done.
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (bvalid) begin
          data_d  = '0;
          err_d   = bresp;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      data_q    <= '0;
      err_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      data_q    <= data_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    req_ready = (!rst && state_q == IDLE) ? gnt_oh : '0;
    arvalid   = !rst && state_q == RD_ADDR;
    rready    = !rst && state_q == RD_RESP;
    awvalid   = !rst && state_q == WR_ADDR && !aw_done_q;
    wvalid    = !rst && state_q == WR_ADDR && !w_done_q;
    bready    = !rst && state_q == WR_RESP;
    araddr    = addr_q;
    awaddr    = addr_q;
    wdata     = wdata_q;
    resp_data = rst ? '0 : data_q;
    resp_err  = rst ? '0 : err_q;
    resp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = !rst && state_q == RESP && (i == 32'(id_q));
    end
  end

endmodule

// File: tb/tb_esi_mmio_arbiter.sv
// Bench for esi_mmio_arbiter (3 requesters): directed vector table, hand sequences,
// and randomized transactions checked against a round-robin reference model.
module tb_esi_mmio_arbiter;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_ready, req_write, resp_valid;
  logic [32*N-1:0] req_addr, req_wdata;
  logic [31:0]   resp_data, araddr, rdata, awaddr, wdata;
  logic [1:0]    resp_err, rresp, bresp;
  logic          arvalid, arready, rvalid, rready;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;

  esi_mmio_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int ptr_m = 0;
  logic [31:0] last_data = '0;
  logic [1:0]  last_err = '0;

  typedef struct {
    logic [N-1:0] mask;
    logic [N-1:0] hold;
    int           exp_id;
    logic         wr;
    logic [31:0]  addr;
    logic [31:0]  data;
    int           da;
    int           db;
    int           dr;
    logic [31:0]  rd;
    logic [1:0]   rs;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [N-1:0] onehot(input int id);
    logic [N-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // Reference arbitration: first requesting index at or after the pointer, modulo N.
  function automatic int model_grant(input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) begin
      if (mask[(ptr_m + k) % N]) return (ptr_m + k) % N;
    end
    return -1;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 0);
    check({tag, "_arvalid"}, 32'(arvalid), 0);
    check({tag, "_awvalid"}, 32'(awvalid), 0);
    check({tag, "_wvalid"}, 32'(wvalid), 0);
    check({tag, "_rready"}, 32'(rready), 0);
    check({tag, "_bready"}, 32'(bready), 0);
  endtask

  // One full transaction; da = arready cycle (read) or awready cycle (write),
  // db = wready cycle, dr = cycles of response wait before rvalid/bvalid.
  task automatic txn(input logic [N-1:0] mask, input logic [N-1:0] hold, input logic keep,
                     input int id, input logic wr, input logic [31:0] addr,
                     input logic [31:0] data, input int da, input int db, input int dr,
                     input logic [31:0] rd, input logic [1:0] rs, input logic spur);
    logic [31:0] exp_d;
    int last;
    @(negedge clk);
    req_valid = mask;
    req_write = N'($urandom);
    req_addr  = {$urandom, $urandom, $urandom};
    req_wdata = {$urandom, $urandom, $urandom};
    req_write[id] = wr;
    req_addr[32*id +: 32]  = addr;
    req_wdata[32*id +: 32] = data;
    #1;
    check("grant_ready", 32'(req_ready), 32'(onehot(id)));
    check("resp_one_cycle", 32'(resp_valid), 0);
    check("resp_data_hold", resp_data, last_data);
    check("resp_err_hold", 32'(resp_err), 32'(last_err));
    ptr_m = (id + 1) % N;
    @(negedge clk);
    req_valid = hold;
    if (!wr) begin
      for (int c = 0; c <= da; c++) begin
        if (c > 0) @(negedge clk);
        arready = (c == da);
        bvalid  = spur ? 1'($urandom) : 1'b0;
        #1;
        check("arvalid", 32'(arvalid), 1);
        check("araddr", araddr, addr);
        check("no_regrant", 32'(req_ready), 0);
        check("rready_in_ar", 32'(rready), 0);
      end
      for (int c = 0; c <= dr; c++) begin
        @(negedge clk);
        arready = 1'b0;
        rvalid  = (c == dr);
        rdata   = (c == dr) ? rd : $urandom;
        rresp   = (c == dr) ? rs : 2'($urandom);
        bvalid  = spur ? 1'($urandom) : 1'b0;
        #1;
        check("arvalid_drop", 32'(arvalid), 0);
        check("rready", 32'(rready), 1);
        check("no_early_resp", 32'(resp_valid), 0);
      end
      exp_d = rd;
    end else begin
      last = (da > db) ? da : db;
      for (int c = 0; c <= last; c++) begin
        if (c > 0) @(negedge clk);
        awready = (c == da);
        wready  = (c == db);
        rvalid  = spur ? 1'($urandom) : 1'b0;
        #1;
        check("awvalid", 32'(awvalid), 32'(c <= da));
        check("wvalid", 32'(wvalid), 32'(c <= db));
        if (c <= da) check("awaddr", awaddr, addr);
        if (c <= db) check("wdata", wdata, data);
        check("bready_in_aw", 32'(bready), 0);
      end
      for (int c = 0; c <= dr; c++) begin
        @(negedge clk);
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = (c == dr);
        bresp   = (c == dr) ? rs : 2'($urandom);
        rvalid  = spur ? 1'($urandom) : 1'b0;
        #1;
        check("aw_w_idle", 32'({awvalid, wvalid}), 0);
        check("bready", 32'(bready), 1);
        check("no_early_resp", 32'(resp_valid), 0);
      end
      exp_d = '0;
    end
    @(negedge clk);
    rvalid = 1'b0;
    bvalid = 1'b0;
    req_valid = keep ? hold : '0;
    #1;
    check("resp_valid", 32'(resp_valid), 32'(onehot(id)));
    check("resp_data", resp_data, exp_d);
    check("resp_err", 32'(resp_err), 32'(rs));
    check("bus_idle_in_resp", 32'({arvalid, awvalid, wvalid, rready, bready}), 0);
    last_data = exp_d;
    last_err  = rs;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    logic [N-1:0] m;
    int id;

    tbl[0] = '{3'b001, 3'b000, 0, 1'b0, 32'h10, 32'h0, 0, 0, 0, 32'hCAFEF00D, 2'd0};
    tbl[1] = '{3'b010, 3'b000, 1, 1'b1, 32'h20, 32'h5, 0, 2, 0, 32'h0, 2'd2};
    tbl[2] = '{3'b001, 3'b111, 0, 1'b0, 32'h44, 32'h0, 10, 0, 1, 32'hA5A50001, 2'd0};
    tbl[3] = '{3'b100, 3'b000, 2, 1'b1, 32'h30, 32'hDEADBEEF, 0, 0, 1, 32'h0, 2'd0};
    tbl[4] = '{3'b011, 3'b000, 0, 1'b1, 32'h34, 32'h1234, 3, 1, 0, 32'h0, 2'd1};
    tbl[5] = '{3'b101, 3'b011, 2, 1'b0, 32'h38, 32'h0, 1, 0, 2, 32'h12345678, 2'd3};
    tbl[6] = '{3'b110, 3'b000, 1, 1'b0, 32'h3C, 32'h0, 2, 0, 0, 32'hFFFFFFFF, 2'd0};

    rst = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = '0;
    repeat (3) @(negedge clk);
    #1;
    check_quiet("reset");
    check("reset_resp_data", resp_data, 0);
    check("reset_resp_err", 32'(resp_err), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i])
      txn(tbl[i].mask, tbl[i].hold, 1'b0, tbl[i].exp_id, tbl[i].wr, tbl[i].addr, tbl[i].data,
          tbl[i].da, tbl[i].db, tbl[i].dr, tbl[i].rd, tbl[i].rs, 1'b0);

    // Spurious rvalid/bvalid while idle must be ignored.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rvalid = 1'b1; bvalid = 1'b1; rdata = $urandom; rresp = 2'($urandom); bresp = 2'($urandom);
      #1;
      check_quiet("spurious_idle");
    end
    @(negedge clk);
    rvalid = 1'b0; bvalid = 1'b0;
    // Read with spurious bvalid in RD_ADDR/RD_RESP (pointer at 2, so req0 wins).
    txn(3'b001, 3'b000, 1'b0, 0, 1'b0, 32'h50, 32'h0, 1, 0, 3, 32'h0BADF00D, 2'd1, 1'b1);

    // Reset while in RD_RESP: transaction abandoned, pointer returns to 0.
    @(negedge clk);
    req_valid = 3'b010; req_write = 3'b000; req_addr[63:32] = 32'h60;
    #1;
    check("rst_seq_grant", 32'(req_ready), 32'(onehot(1)));
    @(negedge clk);
    req_valid = '0; arready = 1'b1;
    #1;
    check("rst_seq_arvalid", 32'(arvalid), 1);
    @(negedge clk);
    arready = 1'b0;
    #1;
    check("rst_seq_rready", 32'(rready), 1);
    rst = 1'b1;
    rvalid = 1'b1; rdata = 32'h77777777; rresp = 2'd3;
    #1;
    check_quiet("rst_high");
    @(negedge clk);
    #1;
    check_quiet("rst_held");
    check("rst_resp_data", resp_data, 0);
    @(negedge clk);
    rst = 1'b0; rvalid = 1'b0;
    #1;
    check_quiet("after_rst");
    @(negedge clk);
    #1;
    check_quiet("after_rst2");
    last_data = '0; last_err = '0; ptr_m = 0;

    // All requesters held high: strict rotation 0,1,2,0,1,2.
    for (int i = 0; i < 6; i++)
      txn(3'b111, 3'b111, i < 5, i % N, i[0], 32'h100 + 32'(i), 32'h200 + 32'(i),
          i % 3, (i + 1) % 3, i % 2, 32'h300 + 32'(i), 2'(i), 1'b0);

    for (int i = 0; i < 40; i++) begin
      m  = N'($urandom_range(1, 7));
      id = model_grant(m);
      txn(m, N'($urandom), 1'b0, id, 1'($urandom), $urandom, $urandom,
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom, 2'($urandom), 1'($urandom));
    end

    @(negedge clk);
    #1;
    check("final_resp_one_cycle", 32'(resp_valid), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
